env_dac: RTL and testbench
==========================

# env_dac

Output stage of the music path: takes signed 8-bit wave samples and note-on/note-off strobes from the note sequencer, applies an ADSR-style volume envelope, and converts the result to a 1-bit first-order delta-sigma stream that drives the piezo buzzer. It sits between the sequencer and the BP2 pin; the top level inverts `q` onto BP2.

## Interface
- `ENV_DIV`, 12000: CLK cycles per envelope tick (1 ms at 12 MHz); ≥2
- `ATTACK_STEP`, 32: envelope increment per tick in ATTACK
- `DECAY_STEP`, 4: decrement per tick in DECAY
- `SUSTAIN_LVL`, 160: hold level, 1..255
- `RELEASE_STEP`, 8: decrement per tick in RELEASE
- `CLK` in 1: sole clock, rising edge
- `RST` in 1: asynchronous, active-high reset
- `wave` in 8 signed: sample from sequencer
- `wave_valid` in 1: one-cycle strobe; `wave` captured when high
- `note_on` in 1: one-cycle pulse, start/retrigger note
- `note_off` in 1: one-cycle pulse, release note
- `mute` in 1: level, silences output
- `env_level` out 8: current envelope, unsigned
- `active` out 1: envelope state ≠ IDLE
- `q` out 1: delta-sigma bit, 1 = pulse density high

## Operation
- Reset (async): state IDLE, `env_level`=0, sample register 0, scaled register 0, accumulator 0, prescaler 0, `q`=0, `active`=0.
- Sample path: `wave_valid` latches `wave` into sample_r. scaled_r = (sample_r × env_level) >>> 8: signed 8 × unsigned 8 → signed 17-bit product, arithmetic shift (floor), result fits signed 8.
- Modulator: u = scaled_r + 128 as 8-bit unsigned (0..255). {carry, acc[7:0]} = acc + u; `q` ← carry. Ones density over 256 cycles = u/256.
- Silence: in IDLE or with `mute`=1, acc held at 0 and `q` forced 0 (constant, no 50% buzz). Envelope keeps running under `mute`.
- Prescaler counts 0..ENV_DIV-1; tick when it wraps. Cleared by `note_on`.
- FSM (all level changes only on tick, saturating arithmetic):
  - IDLE: env 0. `note_on` → ATTACK.
  - ATTACK: env += ATTACK_STEP, clamp 255; reaching 255 → DECAY.
  - DECAY: env -= DECAY_STEP; if result ≤ SUSTAIN_LVL, env = SUSTAIN_LVL → SUSTAIN.
  - SUSTAIN: hold.
  - RELEASE: env -= RELEASE_STEP, clamp 0; reaching 0 → IDLE.
  - `note_on` in any state → ATTACK, env kept (no click on retrigger).
  - `note_off` in ATTACK/DECAY/SUSTAIN → RELEASE; ignored in IDLE/RELEASE.
  - `note_on` and `note_off` same cycle: `note_on` wins.
- `wave_valid` with no note: sample captured, output stays 0 (env 0, IDLE).

## Timing
- `note_on` at cycle t: state ATTACK and `active`=1 at t+1; first envelope step at t+ENV_DIV.
- `wave_valid` at t: sample_r at t+1, scaled_r at t+2, first `q` affected at t+3.
- `env_level` change propagates to scaled_r one cycle later.
- RELEASE→IDLE on the tick env hits 0; `active`=0 and `q`=0 next cycle.
- `RST` asserted mid-note: all outputs 0 immediately; after release waits for `note_on`.

## Structure
- Shared package `music_pkg`: FSM state encodings (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), 8-bit sample/level width constants, silence offset 128.
- One sub-module `dsm_1bit`: 8-bit unsigned input, `hold_zero` input, 9-bit accumulator, registered `q`. FSM, prescaler and scaler stay in `env_dac`.

## Test plan
- ENV_DIV=4, defaults; `note_on` → `env_level` 32,64,…,224,255 on ticks 1–8, DECAY, falls by 4 to 160 after 24 more ticks, SUSTAIN, `active`=1 throughout.
- In SUSTAIN with SUSTAIN_LVL=255, wave=127 steady → scaled 126, exactly 254 ones in 256 cycles; wave=-128 → scaled -128, `q` all 0; wave=0 → 128 ones.
- `note_off` in SUSTAIN (160) → RELEASE, 20 ticks to 0, IDLE, `active`=0 and `q`=0 next cycle.
- In RELEASE at env 80, `note_on`+`note_off` same cycle → ATTACK, next tick env 112.
- `mute`=1 during SUSTAIN → `q` constant 0 while `env_level` unchanged; `mute`=0 → density resumes within 3 cycles.
- `RST` pulse mid-ATTACK (env 96) → `env_level`, `q`, `active` 0 asynchronously; ignores `wave_valid` output until next `note_on`.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the music output path: envelope states, sample/level
// widths and the offset that maps a signed sample onto the unsigned modulator input.
package music_pkg;

    localparam int SAMPLE_W = 8;
    localparam int LEVEL_W  = 8;
    localparam logic [LEVEL_W-1:0] SILENCE_OFFSET = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    // Signed sample to unsigned modulator code; 0 maps to mid-scale.
    function automatic logic [LEVEL_W-1:0] to_offset_binary(input logic signed [SAMPLE_W-1:0] s);
        return LEVEL_W'(s) + SILENCE_OFFSET;
    endfunction

endpackage

// File: rtl/env_dac_dsm_1bit.sv
// First-order 1-bit delta-sigma modulator; carry out of an 8-bit phase
// accumulator is the output bit, so ones density equals u/256.
module dsm_1bit
    import music_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] u,
    input  logic               hold_zero,
    output logic               q
);

    logic [LEVEL_W:0] acc_q;
    logic [LEVEL_W:0] acc_d;

    // Next accumulator value; bit 8 holds the carry that becomes q.
    always_comb begin
        acc_d = '0;
        if (hold_zero) begin
            acc_d = '0;
        end else begin
            acc_d = {1'b0, acc_q[LEVEL_W-1:0]} + {1'b0, u};
        end
    end

    // Accumulator register with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign q = acc_q[LEVEL_W];

endmodule

// File: rtl/env_dac.sv
// Music output stage: ADSR envelope applied to the sequencer's wave samples,
// then converted to a 1-bit delta-sigma stream for the buzzer.
module env_dac
    import music_pkg::*;
#(
    parameter int ENV_DIV      = 12000,
    parameter int ATTACK_STEP  = 32,
    parameter int DECAY_STEP   = 4,
    parameter int SUSTAIN_LVL  = 160,
    parameter int RELEASE_STEP = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic signed [SAMPLE_W-1:0] wave,
    input  logic                       wave_valid,
    input  logic                       note_on,
    input  logic                       note_off,
    input  logic                       mute,
    output logic        [LEVEL_W-1:0]  env_level,
    output logic                       active,
    output logic                       q
);

    localparam int PRE_W = (ENV_DIV > 2) ? $clog2(ENV_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(ENV_DIV - 1);
    localparam logic [LEVEL_W:0] ATK9 = 9'(ATTACK_STEP);
    localparam logic [LEVEL_W:0] DEC9 = 9'(DECAY_STEP);
    localparam logic [LEVEL_W:0] REL9 = 9'(RELEASE_STEP);
    localparam logic [LEVEL_W:0] SUS9 = 9'(SUSTAIN_LVL);

    env_state_e                  state_q, state_d;
    logic        [LEVEL_W-1:0]   env_q, env_d;
    logic        [PRE_W-1:0]     pre_q, pre_d;
    logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
    logic signed [SAMPLE_W-1:0]  scaled_q, scaled_d;
    logic                        active_q, active_d;
    logic                        tick_s;
    logic        [LEVEL_W:0]     env9_s;
    logic signed [15:0]          samp_x_s, env_x_s, prod_s;
    logic                        hold_zero_s;

    assign tick_s = (pre_q == PRE_MAX);
    assign env9_s = {1'b0, env_q};

    // Envelope tick prescaler; note_on realigns it so the first step is a full period away.
    always_comb begin
        pre_d = pre_q;
        if (note_on || tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Envelope FSM: strobes act immediately, level changes only on a tick.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (note_on) begin
            state_d = ST_ATTACK;
        end else if (note_off && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
            state_d = ST_RELEASE;
        end else if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    env_d = '0;
                end
                ST_ATTACK: begin
                    if (env9_s + ATK9 >= 9'd255) begin
                        env_d   = 8'd255;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = env_q + 8'(ATTACK_STEP);
                    end
                end
                ST_DECAY: begin
                    if (env9_s <= SUS9 + DEC9) begin
                        env_d   = 8'(SUSTAIN_LVL);
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = env_q - 8'(DECAY_STEP);
                    end
                end
                ST_SUSTAIN: begin
                    env_d = env_q;
                end
                ST_RELEASE: begin
                    if (env9_s <= REL9) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - 8'(RELEASE_STEP);
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sample capture and envelope scaling (signed x unsigned, floor shift by 8).
    always_comb begin
        sample_d = wave_valid ? wave : sample_q;
        samp_x_s = {{8{sample_q[SAMPLE_W-1]}}, sample_q};
        env_x_s  = {8'd0, env_q};
        prod_s   = samp_x_s * env_x_s;
        scaled_d = SAMPLE_W'(prod_s >>> 8);
        active_d = (state_d != ST_IDLE);
    end

    // Silence uses the next state so q drops in the same cycle the envelope goes idle.
    assign hold_zero_s = (state_d == ST_IDLE) || mute;

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            env_q    <= '0;
            pre_q    <= '0;
            sample_q <= '0;
            scaled_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            pre_q    <= pre_d;
            sample_q <= sample_d;
            scaled_q <= scaled_d;
            active_q <= active_d;
        end
    end

    dsm_1bit u_dsm (
        .clk       (CLK),
        .rst       (RST),
        .u         (to_offset_binary(scaled_q)),
        .hold_zero (hold_zero_s),
        .q         (q)
    );

    assign env_level = env_q;
    assign active    = active_q;

endmodule

// File: tb/tb_env_dac.sv
// Bench for env_dac: two instances (sustain 160 and 255) share stimulus and are
// compared every cycle against an arithmetic model, plus hand-computed checkpoints.
module tb_env_dac;

    localparam int DIV = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic signed [7:0] wave;
    logic              wave_valid, note_on, note_off, mute;
    logic        [7:0] env_a, env_b;
    logic              active_a, active_b, q_a, q_b;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    env_dac #(.ENV_DIV(DIV), .SUSTAIN_LVL(160)) dut_a (
        .CLK(CLK), .RST(RST), .wave(wave), .wave_valid(wave_valid),
        .note_on(note_on), .note_off(note_off), .mute(mute),
        .env_level(env_a), .active(active_a), .q(q_a)
    );

    env_dac #(.ENV_DIV(DIV), .SUSTAIN_LVL(255)) dut_b (
        .CLK(CLK), .RST(RST), .wave(wave), .wave_valid(wave_valid),
        .note_on(note_on), .note_off(note_off), .mute(mute),
        .env_level(env_b), .active(active_b), .q(q_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. States: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    int sus_lvl [2] = '{160, 255};
    int m_st [2], m_env [2], m_samp [2], m_scaled [2], m_acc [2], m_q [2], m_act [2];
    int m_pre;

    always @(posedge CLK or posedge RST) begin : model
        int st, env, p, s, tick;
        if (RST) begin
            m_pre = 0;
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_env[i] = 0; m_samp[i] = 0; m_scaled[i] = 0;
                m_acc[i] = 0; m_q[i] = 0; m_act[i] = 0;
            end
        end else begin
            tick = (m_pre == DIV - 1);
            for (int i = 0; i < 2; i++) begin
                st  = m_st[i];
                env = m_env[i];
                if (note_on) st = 1;
                else if (note_off && st >= 1 && st <= 3) st = 4;
                else if (tick) begin
                    case (st)
                        0: env = 0;
                        1: begin env = env + 32; if (env >= 255) begin env = 255; st = 2; end end
                        2: begin env = env - 4; if (env <= sus_lvl[i]) begin env = sus_lvl[i]; st = 3; end end
                        4: begin env = env - 8; if (env <= 0) begin env = 0; st = 0; end end
                        default: ;
                    endcase
                end
                if (st == 0 || mute) begin
                    m_acc[i] = 0; m_q[i] = 0;
                end else begin
                    s = m_acc[i] + m_scaled[i] + 128;
                    m_q[i] = s / 256; m_acc[i] = s % 256;
                end
                p = m_samp[i] * m_env[i];
                m_scaled[i] = (p >= 0) ? p / 256 : -((-p + 255) / 256);
                if (wave_valid) m_samp[i] = wave;
                m_env[i] = env;
                m_st[i]  = st;
                m_act[i] = (st != 0);
            end
            m_pre = note_on ? 0 : (tick ? 0 : m_pre + 1);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        chk("model_env_a", env_a, m_env[0]);
        chk("model_act_a", active_a, m_act[0]);
        chk("model_q_a", q_a, m_q[0]);
        chk("model_env_b", env_b, m_env[1]);
        chk("model_act_b", active_b, m_act[1]);
        chk("model_q_b", q_b, m_q[1]);
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic pulse_on();
        note_on = 1'b1; cyc(); note_on = 1'b0;
    endtask

    task automatic pulse_off();
        note_off = 1'b1; cyc(); note_off = 1'b0;
    endtask

    task automatic wait_chg(input int inst, output int v);
        int old;
        old = inst ? int'(env_b) : int'(env_a);
        v = -1;
        for (int c = 0; c < 3 * DIV + 4; c++) begin
            @(negedge CLK);
            if ((inst ? int'(env_b) : int'(env_a)) != old) begin
                v = inst ? int'(env_b) : int'(env_a);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_chg: inst %0d env stuck at %0d, expected a change", inst, old);
    endtask

    task automatic count_q(input int n, output int ca, output int cb);
        ca = 0; cb = 0;
        repeat (n) begin
            @(negedge CLK);
            ca += int'(q_a); cb += int'(q_b);
        end
    endtask

    task automatic density(input logic signed [7:0] w, input int exp_a, input int exp_b);
        int ca, cb;
        wave = w; wave_valid = 1'b1; cyc(); wave_valid = 1'b0;
        repeat (4) cyc();
        count_q(256, ca, cb);
        chk("density_a", ca, exp_a);
        chk("density_b", cb, exp_b);
    endtask

    initial begin : stim
        int v, ca, cb;
        RST = 1'b0; wave = '0; wave_valid = 1'b0; note_on = 1'b0; note_off = 1'b0; mute = 1'b0;
        #2 RST = 1'b1;
        repeat (3) cyc();
        RST = 1'b0;
        chk("reset_env", env_a, 0);
        chk("reset_active", active_a, 0);
        chk("reset_q", q_a, 0);

        pulse_on();
        chk("on_active", active_a, 1);
        for (int k = 1; k <= 8; k++) begin
            wait_chg(0, v);
            chk("attack_step", v, (k < 8) ? 32 * k : 255);
        end
        for (int k = 1; k <= 24; k++) begin
            wait_chg(0, v);
            chk("decay_step", v, (k < 24) ? 255 - 4 * k : 160);
        end
        chk("sustain_active", active_a, 1);
        repeat (3 * DIV) cyc();
        chk("sustain_hold_a", env_a, 160);
        chk("sustain_hold_b", env_b, 255);

        density(8'sd127, 207, 254);
        density(-8'sd128, 48, 0);
        density(8'sd0, 128, 128);

        mute = 1'b1;
        repeat (2) cyc();
        count_q(100, ca, cb);
        chk("mute_q_a", ca, 0);
        chk("mute_q_b", cb, 0);
        chk("mute_env_a", env_a, 160);
        chk("mute_env_b", env_b, 255);
        mute = 1'b0;
        repeat (3) cyc();
        count_q(256, ca, cb);
        chk("unmute_a", ca, 128);
        chk("unmute_b", cb, 128);

        pulse_off();
        for (int k = 1; k <= 20; k++) begin
            wait_chg(0, v);
            chk("release_step", v, 160 - 8 * k);
        end
        chk("idle_active_a", active_a, 0);
        chk("idle_q_a", q_a, 0);
        repeat (60) cyc();
        chk("idle_env_b", env_b, 0);
        chk("idle_active_b", active_b, 0);

        pulse_on();
        for (int k = 1; k <= 4; k++) begin
            wait_chg(0, v);
            chk("reattack_step", v, 32 * k);
        end
        pulse_off();
        for (int k = 1; k <= 6; k++) begin
            wait_chg(0, v);
            chk("rel_to_80", v, 128 - 8 * k);
        end
        note_on = 1'b1; note_off = 1'b1; cyc(); note_on = 1'b0; note_off = 1'b0;
        chk("both_active", active_a, 1);
        wait_chg(0, v);
        chk("retrigger_a", v, 112);
        chk("retrigger_b", env_b, 112);

        #1 RST = 1'b1;
        cyc();
        RST = 1'b0;
        pulse_on();
        for (int k = 1; k <= 3; k++) begin
            wait_chg(0, v);
            chk("pre_rst_attack", v, 32 * k);
        end
        #1 RST = 1'b1;
        #1;
        chk("rst_async_env_a", env_a, 0);
        chk("rst_async_act_a", active_a, 0);
        chk("rst_async_q_a", q_a, 0);
        chk("rst_async_env_b", env_b, 0);
        cyc();
        RST = 1'b0;
        wave = 8'sd127; wave_valid = 1'b1; cyc(); wave_valid = 1'b0;
        count_q(300, ca, cb);
        chk("post_rst_q_a", ca, 0);
        chk("post_rst_q_b", cb, 0);
        chk("post_rst_active", active_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
